// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bundle for jk_cmd_sequencer: valid/ready plus the op and repeat fields.
// A command transfers on a rising clk edge where valid and ready are both high; op/rep must be stable while valid is high.
interface jk_cmd_sequencer_if #(
  parameter int CNT_W = 4
) ();
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [CNT_W-1:0] rep;

  modport master (output valid, output op, output rep, input ready);
  modport slave  (input valid, input op, input rep, output ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands in a FIFO and replays each j/k pattern for rep+1 cycles, tracking the expected flop q.
// Optional macro JKSEQ_CHECK_EN builds the q_fb compare and sticky mismatch flag; otherwise mismatch is tied to 0.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  jk_cmd_sequencer_if.slave   cmd,
  output logic                j,
  output logic                k,
  input  logic                q_fb,
  output logic                q_model,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic                fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2 + CNT_W;
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, push, pop, ready_en;
  logic             load, clear_jk;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_rep;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd.ready = ready_en & ~full;
  assign push      = cmd.valid & cmd.ready;
  assign head_op   = mem[rd_ptr[AW-1:0]][EW-1 -: 2];
  assign head_rep  = mem[rd_ptr[AW-1:0]][CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd.op, cmd.rep};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    clear_jk  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          if (!empty) begin
            // Chain straight into the next command so there is no HOLD gap.
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            clear_jk  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j   <= 1'b0;
      k   <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      j   <= head_op[1];
      k   <= head_op[0];
      cnt <= head_rep;
    end else if (clear_jk) begin
      j   <= 1'b0;
      k   <= 1'b0;
    end else if (state == DRIVE) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy      = (state == DRIVE);
  assign done      = (state == DRIVE) && (cnt == '0);
  assign fsm_state = state;

  // Model follows the j/k currently presented, so it updates on the same edge as the real flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_model <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

`ifdef JKSEQ_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 mismatch <= 1'b0;
    else if (q_fb != q_model)   mismatch <= 1'b1;
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule
